axi4_burst_mem_slave: RTL

Parametrised AXI4 full-protocol slave backed by an internal register-array memory. Generalises the fixed 32-bit, 8-beat INCR example slave with configurable data/address/ID width and depth, FIXED/INCR/WRAP bursts, WSTRB byte enables, ID echo and SLVERR on out-of-range beats. Sits behind the interconnect as a bus-attached scratch memory and bench target for master-VIP burst tests.

---
 rtl/axi4_burst_mem_slave_if.sv | 66 ++++++
 rtl/axi4_burst_mem_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_mem_slave_if
// Description : AXI4 bus bundle (AW/W/B/AR/R) for the burst memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_burst_mem_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [ID_WIDTH-1:0]     S_AXI_AWID;
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic [1:0]              S_AXI_AWBURST;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [ID_WIDTH-1:0]     S_AXI_BID;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ID_WIDTH-1:0]     S_AXI_ARID;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic [1:0]              S_AXI_ARBURST;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [ID_WIDTH-1:0]     S_AXI_RID;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi4_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_mem_slave
// Description : AXI4 burst slave (FIXED/INCR/WRAP) over a register-array memory.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_MEM_DEPTH        = 256
) (
  input wire logic              ACLK,
  input wire logic              ARESET,
  axi4_burst_mem_slave_if.slave s_axi
);
  localparam int AW         = C_S_AXI_ADDR_WIDTH;
  localparam int DW         = C_S_AXI_DATA_WIDTH;
  localparam int BYTES      = DW / 8;
  localparam int ADDR_SHIFT = $clog2(BYTES);
  localparam int IDX_W      = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(C_MEM_DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic wrap_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_WRAP) &&
           !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [7:0] len,
                                              input logic [1:0] burst);
    logic [AW-1:0] step;
    logic [AW-1:0] mask;
    step = addr + AW'(BYTES);
    mask = AW'((32'(len) + 32'd1) * 32'(BYTES) - 32'd1);
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP && !wrap_bad(burst, len)) return (addr & ~mask) | (step & mask);
    return step;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, (addr >> ADDR_SHIFT)} < DEPTH_L;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] addr);
    return IDX_W'(addr >> ADDR_SHIFT);
  endfunction

  logic [DW-1:0] mem_q [C_MEM_DEPTH];

  // ---------------- write channel ----------------
  logic [1:0]                  wstate_q, wstate_d;
  logic [C_S_AXI_ID_WIDTH-1:0] awid_q;
  logic [AW-1:0]               waddr_q;
  logic [7:0]                  awlen_q, wcnt_q;
  logic [1:0]                  awburst_q;
  logic                        werr_q, wbad_q;
  logic                        w_awready, w_wready, w_bvalid;
  logic [1:0]                  w_bresp;
  logic                        w_aw_hs, w_w_hs, w_wbeat_ok, w_wlast_beat;

  assign w_aw_hs      = w_awready && s_axi.S_AXI_AWVALID;
  assign w_w_hs       = w_wready && s_axi.S_AXI_WVALID;
  assign w_wbeat_ok   = !wbad_q && in_range(waddr_q);
  assign w_wlast_beat = (wcnt_q == awlen_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wstate_q <= W_IDLE;
    else        wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (s_axi.S_AXI_AWVALID) wstate_d = W_DATA;
      W_DATA:  if (s_axi.S_AXI_WVALID && w_wlast_beat) wstate_d = W_RESP;
      W_RESP:  if (s_axi.S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    w_bresp   = RESP_OKAY;
    case (wstate_q)
      W_IDLE:  w_awready = !ARESET;
      W_DATA:  w_wready  = 1'b1;
      W_RESP: begin
        w_bvalid = 1'b1;
        w_bresp  = werr_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Termination is by beat count; a WLAST that disagrees only flags the error.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awburst_q <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wbad_q    <= 1'b0;
    end else if (w_aw_hs) begin
      awid_q    <= s_axi.S_AXI_AWID;
      waddr_q   <= s_axi.S_AXI_AWADDR;
      awlen_q   <= s_axi.S_AXI_AWLEN;
      awburst_q <= s_axi.S_AXI_AWBURST;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wbad_q    <= wrap_bad(s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWLEN);
    end else if (w_w_hs) begin
      waddr_q <= next_addr(waddr_q, awlen_q, awburst_q);
      wcnt_q  <= wcnt_q + 8'd1;
      werr_q  <= werr_q | !w_wbeat_ok | (s_axi.S_AXI_WLAST != w_wlast_beat);
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_w_hs && w_wbeat_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) mem_q[word_idx(waddr_q)][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = w_bvalid;
  assign s_axi.S_AXI_BRESP   = w_bresp;
  assign s_axi.S_AXI_BID     = awid_q;

  // ---------------- read channel ----------------
  logic [0:0]                  rstate_q, rstate_d;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q;
  logic [AW-1:0]               raddr_q;
  logic [7:0]                  arlen_q, rcnt_q;
  logic [1:0]                  arburst_q;
  logic                        rbad_q;
  logic [DW-1:0]               rdata_q;
  logic [1:0]                  rresp_q;
  logic                        rlast_q;
  logic                        w_arready, w_rvalid, w_rlast;
  logic                        w_ar_hs, w_r_hs, w_rd_load, w_rd_ok, w_rd_bad;
  logic [AW-1:0]               w_rd_addr;
  logic [7:0]                  w_rd_len, w_rd_cnt;
  logic [1:0]                  w_rd_burst;

  assign w_ar_hs   = w_arready && s_axi.S_AXI_ARVALID;
  assign w_r_hs    = w_rvalid && s_axi.S_AXI_RREADY;
  assign w_rd_load = w_ar_hs || (w_r_hs && !rlast_q);

  // raddr_q always holds the address of the beat that follows the one on the bus.
  assign w_rd_addr  = w_ar_hs ? s_axi.S_AXI_ARADDR  : raddr_q;
  assign w_rd_len   = w_ar_hs ? s_axi.S_AXI_ARLEN   : arlen_q;
  assign w_rd_burst = w_ar_hs ? s_axi.S_AXI_ARBURST : arburst_q;
  assign w_rd_bad   = w_ar_hs ? wrap_bad(s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARLEN) : rbad_q;
  assign w_rd_cnt   = w_ar_hs ? 8'd0 : rcnt_q + 8'd1;
  assign w_rd_ok    = !w_rd_bad && in_range(w_rd_addr);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rstate_q <= R_IDLE;
    else        rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    if (rstate_q == R_IDLE) begin
      if (s_axi.S_AXI_ARVALID) rstate_d = R_DATA;
    end else if (s_axi.S_AXI_RREADY && rlast_q) begin
      rstate_d = R_IDLE;
    end
  end

  always_comb begin
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    w_rlast   = 1'b0;
    if (rstate_q == R_IDLE) begin
      w_arready = !ARESET;
    end else begin
      w_rvalid = 1'b1;
      w_rlast  = rlast_q;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rid_q     <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arburst_q <= '0;
      rbad_q    <= 1'b0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else if (w_rd_load) begin
      if (w_ar_hs) begin
        rid_q     <= s_axi.S_AXI_ARID;
        arlen_q   <= s_axi.S_AXI_ARLEN;
        arburst_q <= s_axi.S_AXI_ARBURST;
        rbad_q    <= w_rd_bad;
      end
      rdata_q <= w_rd_ok ? mem_q[word_idx(w_rd_addr)] : '0;
      rresp_q <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      rlast_q <= (w_rd_cnt == w_rd_len);
      rcnt_q  <= w_rd_cnt;
      raddr_q <= next_addr(w_rd_addr, w_rd_len, w_rd_burst);
    end
  end

  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = w_rvalid;
  assign s_axi.S_AXI_RLAST   = w_rlast;
  assign s_axi.S_AXI_RID     = rid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
endmodule
`default_nettype wire
